// File: rtl/matrix_pkg.sv
// Shared constants and type encodings for the matrix ASCII parser slice.
package matrix_pkg;

  localparam int ELEM_WIDTH = 8;
  localparam int MAX_DIM    = 5;
  localparam int MAT_WIDTH  = MAX_DIM * MAX_DIM * ELEM_WIDTH;
  localparam int ACC_WIDTH  = 12;
  localparam int DIM_WIDTH  = 4;
  localparam int IDX_WIDTH  = 5;
  localparam int ELEM_MAX   = (1 << ELEM_WIDTH) - 1;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;

  typedef enum logic [1:0] {
    ERR_BAD_CHAR = 2'd0,
    ERR_DIM      = 2'd1,
    ERR_OVF      = 2'd2
  } err_code_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GET_M,
    ST_GET_N,
    ST_GET_E
  } parser_state_t;

endpackage

// File: rtl/matrix_ascii_parser_if.sv
// Byte-stream input and parsed-matrix output bundle of the ASCII matrix parser.
interface matrix_ascii_parser_if;
  import matrix_pkg::*;

  logic                 start;
  logic                 rx_valid;
  logic [7:0]           rx_data;
  logic [DIM_WIDTH-1:0] m;
  logic [DIM_WIDTH-1:0] n;
  logic [MAT_WIDTH-1:0] out_matrix;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic [1:0]           err_code;

  modport master (
    output start, rx_valid, rx_data,
    input  m, n, out_matrix, busy, done, error, err_code
  );

  modport slave (
    input  start, rx_valid, rx_data,
    output m, n, out_matrix, busy, done, error, err_code
  );

endinterface

// File: rtl/matrix_ascii_parser_accum.sv
// Decimal token accumulator: classifies each byte, builds the running value
// and flags token ends, bad characters and element overflow.
module ascii_dec_accum
  import matrix_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [7:0]           rx_data,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 is_bad,
  output logic                 token_end,
  output logic                 ovf
);

  logic                   have_digit;
  logic                   is_digit;
  logic                   is_delim;
  logic [3:0]             digit;
  logic [ACC_WIDTH+3:0]   acc_next;

  always_comb begin
    is_digit  = (rx_data >= ASCII_ZERO) && (rx_data <= ASCII_NINE);
    is_delim  = (rx_data == ASCII_SPACE) || (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
    digit     = 4'(rx_data - ASCII_ZERO);
    // Computed wide so the overflow compare sees the true value before truncation
    acc_next  = (ACC_WIDTH+4)'(acc) * (ACC_WIDTH+4)'(10) + (ACC_WIDTH+4)'(digit);
    is_bad    = enable && !is_digit && !is_delim;
    token_end = enable && is_delim && have_digit;
    ovf       = enable && is_digit && (acc_next > (ACC_WIDTH+4)'(ELEM_MAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      have_digit <= 1'b0;
    end else if (clear) begin
      acc        <= '0;
      have_digit <= 1'b0;
    end else if (enable) begin
      if (is_digit) begin
        acc        <= acc_next[ACC_WIDTH-1:0];
        have_digit <= 1'b1;
      end else if (token_end) begin
        acc        <= '0;
        have_digit <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/matrix_ascii_parser.sv
// Parser FSM: turns "m n e0 e1 ..." ASCII text into dimensions plus a packed
// row-major matrix, with registered done/error pulses.
module matrix_ascii_parser
  import matrix_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  matrix_ascii_parser_if.slave bus
);

  parser_state_t        state_q, state_d;
  logic [DIM_WIDTH-1:0] m_q, m_d, n_q, n_d;
  logic [MAT_WIDTH-1:0] matrix_q, matrix_d;
  logic [IDX_WIDTH-1:0] k_q, k_d, total_q, total_d;
  logic                 busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [1:0]           err_q, err_d;

  logic [ACC_WIDTH-1:0] acc;
  logic                 acc_bad, token_end, acc_ovf, dim_ok, fail;
  err_code_t            fail_code;

  ascii_dec_accum u_accum (
    .clk       (clk),
    .rst       (rst),
    .clear     ((state_q == ST_IDLE) && bus.start),
    .enable    ((state_q != ST_IDLE) && bus.rx_valid),
    .rx_data   (bus.rx_data),
    .acc       (acc),
    .is_bad    (acc_bad),
    .token_end (token_end),
    .ovf       (acc_ovf)
  );

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    n_d       = n_q;
    matrix_d  = matrix_q;
    k_d       = k_q;
    total_d   = total_q;
    busy_d    = busy_q;
    err_d     = err_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    fail      = 1'b0;
    fail_code = ERR_BAD_CHAR;
    dim_ok    = (acc >= ACC_WIDTH'(1)) && (acc <= ACC_WIDTH'(MAX_DIM));

    if (state_q == ST_IDLE) begin
      if (bus.start) begin
        matrix_d = '0;
        m_d      = '0;
        n_d      = '0;
        k_d      = '0;
        total_d  = '0;
        busy_d   = 1'b1;
        state_d  = ST_GET_M;
      end
    end else if (acc_bad) begin
      fail      = 1'b1;
      fail_code = ERR_BAD_CHAR;
    end else if ((state_q == ST_GET_E) && acc_ovf) begin
      fail      = 1'b1;
      fail_code = ERR_OVF;
    end else if (token_end) begin
      unique case (state_q)
        ST_GET_M: begin
          if (dim_ok) begin
            m_d     = acc[DIM_WIDTH-1:0];
            state_d = ST_GET_N;
          end else begin
            fail      = 1'b1;
            fail_code = ERR_DIM;
          end
        end
        ST_GET_N: begin
          if (dim_ok) begin
            n_d     = acc[DIM_WIDTH-1:0];
            total_d = IDX_WIDTH'(m_q) * IDX_WIDTH'(acc[DIM_WIDTH-1:0]);
            k_d     = '0;
            state_d = ST_GET_E;
          end else begin
            fail      = 1'b1;
            fail_code = ERR_DIM;
          end
        end
        ST_GET_E: begin
          matrix_d[k_q*ELEM_WIDTH +: ELEM_WIDTH] = acc[ELEM_WIDTH-1:0];
          k_d = k_q + IDX_WIDTH'(1);
          if (k_q + IDX_WIDTH'(1) == total_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
    end

    // Any abort leaves dims and partial matrix as written
    if (fail) begin
      error_d = 1'b1;
      err_d   = fail_code;
      busy_d  = 1'b0;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      m_q      <= '0;
      n_q      <= '0;
      matrix_q <= '0;
      k_q      <= '0;
      total_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      n_q      <= n_d;
      matrix_q <= matrix_d;
      k_q      <= k_d;
      total_q  <= total_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      err_q    <= err_d;
    end
  end

  assign bus.m          = m_q;
  assign bus.n          = n_q;
  assign bus.out_matrix = matrix_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.err_code   = err_q;

endmodule

// File: tb/tb_matrix_ascii_parser.sv
// Scoreboard bench for matrix_ascii_parser: stimulus pushes expected outcomes,
// a monitor pops and compares on every done/error pulse.
module tb_matrix_ascii_parser;
  import matrix_pkg::*;

  typedef struct {
    bit                   is_err;
    logic [1:0]           code;
    logic [3:0]           m;
    logic [3:0]           n;
    logic [MAT_WIDTH-1:0] mat;
    int                   cycle;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests_run = 0;
  int   failures = 0;
  exp_t sb_q[$];

  matrix_ascii_parser_if bus();

  matrix_ascii_parser dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [MAT_WIDTH-1:0] act,
                             input logic [MAT_WIDTH-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pulseStart(input bit with_byte, input logic [7:0] b);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.rx_valid = with_byte;
    bus.rx_data  = b;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
  endtask

  // The expectation is queued as the terminating byte goes out, stamped with
  // the cycle in which its registered pulse must be seen.
  task automatic applyStimulus(input string s, input int term_idx, input exp_t e);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = s[i];
      if (i == term_idx) begin
        e.cycle = cyc + 1;
        sb_q.push_back(e);
      end
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (bus.done || bus.error) begin
      if (sb_q.size() == 0) begin
        tests_run++;
        failures++;
        $display("[TB] FAIL unexpected_pulse: done=%0b error=%0b with nothing expected",
                 bus.done, bus.error);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("pulse_kind", MAT_WIDTH'({bus.done, bus.error}), MAT_WIDTH'({!e.is_err, e.is_err}));
        checkOutput("pulse_cycle", MAT_WIDTH'(cyc), MAT_WIDTH'(e.cycle));
        if (e.is_err) checkOutput("err_code", MAT_WIDTH'(bus.err_code), MAT_WIDTH'(e.code));
        checkOutput("m", MAT_WIDTH'(bus.m), MAT_WIDTH'(e.m));
        checkOutput("n", MAT_WIDTH'(bus.n), MAT_WIDTH'(e.n));
        checkOutput("out_matrix", bus.out_matrix, e.mat);
        checkOutput("busy_at_pulse", MAT_WIDTH'(bus.busy), '0);
      end
    end
  end

  task automatic checkIdleReset(input string tag);
    checkOutput({tag, "_m"}, MAT_WIDTH'(bus.m), '0);
    checkOutput({tag, "_n"}, MAT_WIDTH'(bus.n), '0);
    checkOutput({tag, "_matrix"}, bus.out_matrix, '0);
    checkOutput({tag, "_flags"}, MAT_WIDTH'({bus.busy, bus.done, bus.error, bus.err_code}), '0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t  e;
    string s;

    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    checkIdleReset("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 2x3 matrix; a start pulse mid-parse must not disturb it
    e = '{is_err: 1'b0, code: 2'd0, m: 4'd2, n: 4'd3, mat: '0, cycle: 0};
    for (int k = 0; k < 6; k++) e.mat[k*8 +: 8] = 8'(k + 1);
    pulseStart(1'b0, 8'h00);
    applyStimulus("2 3 1 2 ", -1, e);
    pulseStart(1'b0, 8'h00);
    applyStimulus("3 4 5 6\n", 7, e);
    repeat (3) @(negedge clk);

    // 5x5 of 255 with leading spaces and CRLF
    s = "  5\r\n5 ";
    for (int k = 0; k < 25; k++) s = {s, "255 "};
    e = '{is_err: 1'b0, code: 2'd0, m: 4'd5, n: 4'd5, mat: {MAT_WIDTH{1'b1}}, cycle: 0};
    pulseStart(1'b0, 8'h00);
    applyStimulus(s, s.len() - 1, e);
    repeat (3) @(negedge clk);

    e = '{is_err: 1'b1, code: 2'd1, m: 4'd0, n: 4'd0, mat: '0, cycle: 0};
    pulseStart(1'b0, 8'h00);
    applyStimulus("6 2 1 ", 1, e);
    repeat (3) @(negedge clk);

    e = '{is_err: 1'b1, code: 2'd2, m: 4'd1, n: 4'd1, mat: '0, cycle: 0};
    pulseStart(1'b0, 8'h00);
    applyStimulus("1 1 256 ", 6, e);
    repeat (3) @(negedge clk);

    e = '{is_err: 1'b1, code: 2'd0, m: 4'd2, n: 4'd0, mat: '0, cycle: 0};
    pulseStart(1'b0, 8'h00);
    applyStimulus("2 x", 2, e);
    repeat (2) @(negedge clk);
    e = '{is_err: 1'b0, code: 2'd0, m: 4'd1, n: 4'd1, mat: '0, cycle: 0};
    e.mat[7:0] = 8'd7;
    pulseStart(1'b0, 8'h00);
    applyStimulus("1 1 7 ", 5, e);
    repeat (3) @(negedge clk);

    // Reset mid-parse, then a fresh parse whose start carries a byte to drop
    pulseStart(1'b0, 8'h00);
    applyStimulus("3 3 1 2", -1, e);
    checkOutput("midparse_busy", MAT_WIDTH'(bus.busy), MAT_WIDTH'(1));
    checkOutput("midparse_dims", MAT_WIDTH'({bus.m, bus.n}), MAT_WIDTH'(8'h33));
    rst = 1'b1;
    @(negedge clk);
    checkIdleReset("midreset");
    rst = 1'b0;
    @(negedge clk);
    checkIdleReset("after_reset");
    e = '{is_err: 1'b0, code: 2'd0, m: 4'd2, n: 4'd1, mat: '0, cycle: 0};
    e.mat[7:0]  = 8'd4;
    e.mat[15:8] = 8'd5;
    pulseStart(1'b1, "9");
    applyStimulus("2 1 4 5 ", 7, e);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard_drain", MAT_WIDTH'(sb_q.size()), '0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
